// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Interlock and forwarding controller for a 5-stage IF/ID/EXE/MEM/WB core.
//   It keeps a shadow copy of the destination-register info of the EXE, MEM
//   and WB slots. Every cycle it decides whether the ID instruction issues,
//   stalls or is flushed, and it picks the operand forwarding source for
//   rj/rk. A fixed-latency divider is sequenced by holding EXE.
//
// Parameters
//   DIV_LAT      EXE occupancy of a divide in cycles (>= 1)
// Ports
//   clk, reset               clock, synchronous active-high reset
//   id_valid                 ID holds a valid instruction
//   id_rj, id_rk, id_rd      ID source / destination register numbers
//   id_use_rj, id_use_rk     ID instruction reads rj / rk
//   id_rf_we                 ID instruction writes id_rd
//   id_is_load, id_is_div    ID instruction is a load / uses the divider
//   exe_br_taken             branch resolved taken in EXE this cycle
//   stall_if, stall_id       hold IF / ID registers
//   flush_if, flush_id       invalidate IF / ID registers next edge
//   issue                    ID instruction enters EXE at this edge
//   exe_hold                 EXE holds its instruction (divide running)
//   fwd_rj, fwd_rk           0 RF, 1 EXE, 2 MEM, 3 WB
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int DIV_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rj,
    input  logic [4:0] id_rk,
    input  logic [4:0] id_rd,
    input  logic       id_use_rj,
    input  logic       id_use_rk,
    input  logic       id_rf_we,
    input  logic       id_is_load,
    input  logic       id_is_div,
    input  logic       exe_br_taken,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_if,
    output logic       flush_id,
    output logic       issue,
    output logic       exe_hold,
    output logic [1:0] fwd_rj,
    output logic [1:0] fwd_rk
);

    localparam int            CW       = $clog2(DIV_LAT) + 1;
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Slot shadow registers
    logic          exe_valid_r, exe_we_r, exe_ld_r;
    logic [4:0]    exe_rd_r;
    logic          mem_valid_r, mem_we_r, mem_ld_r;
    logic [4:0]    mem_rd_r;
    logic          wb_valid_r, wb_we_r, wb_ld_r;
    logic [4:0]    wb_rd_r;
    logic [CW-1:0] div_cnt_r;

    // Combinational decision signals
    logic       exe_writer_s, mem_writer_s, wb_writer_s;
    logic       rj_used_s, rk_used_s;
    logic       load_use_s, flush_s, issue_s, hold_s, stall_s;
    logic [1:0] fwd_rj_s, fwd_rk_s;

    // A slot only counts as a writer if it is valid, writes, and targets a
    // register other than r0.
    function automatic logic is_writer(input logic v, input logic we,
                                       input logic [4:0] rd);
        return v & we & (rd != 5'd0);
    endfunction

    // Priority forwarding select for one source operand. An EXE load is not
    // eligible (its data is not ready); the load-use stall covers that case.
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] r,
        input logic       exe_ok,
        input logic [4:0] exe_rd,
        input logic       mem_ok,
        input logic [4:0] mem_rd,
        input logic       wb_ok,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        if (!used) begin
            sel = 2'd0;
        end else if (exe_ok && (exe_rd == r)) begin
            sel = 2'd1;
        end else if (mem_ok && (mem_rd == r)) begin
            sel = 2'd2;
        end else if (wb_ok && (wb_rd == r)) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Hazard detection, issue/stall/flush decisions and forwarding selects
    always_comb begin
        exe_writer_s = is_writer(exe_valid_r, exe_we_r, exe_rd_r);
        mem_writer_s = is_writer(mem_valid_r, mem_we_r, mem_rd_r);
        wb_writer_s  = is_writer(wb_valid_r, wb_we_r, wb_rd_r);

        // r0 is never a real source
        rj_used_s = id_use_rj & (id_rj != 5'd0);
        rk_used_s = id_use_rk & (id_rk != 5'd0);

        hold_s     = (div_cnt_r != CNT_ZERO);
        load_use_s = id_valid & exe_writer_s & exe_ld_r &
                     ((rj_used_s & (id_rj == exe_rd_r)) |
                      (rk_used_s & (id_rk == exe_rd_r)));
        // A branch resolving while the divider holds EXE is not real yet
        flush_s    = exe_br_taken & ~hold_s;
        issue_s    = id_valid & ~load_use_s & ~hold_s & ~flush_s;
        stall_s    = id_valid & (load_use_s | hold_s) & ~flush_s;

        fwd_rj_s = fwd_sel(rj_used_s, id_rj, exe_writer_s & ~exe_ld_r, exe_rd_r,
                           mem_writer_s, mem_rd_r, wb_writer_s, wb_rd_r);
        fwd_rk_s = fwd_sel(rk_used_s, id_rk, exe_writer_s & ~exe_ld_r, exe_rd_r,
                           mem_writer_s, mem_rd_r, wb_writer_s, wb_rd_r);
    end

    assign stall_if = stall_s;
    assign stall_id = stall_s;
    assign flush_if = flush_s;
    assign flush_id = flush_s;
    assign issue    = issue_s;
    assign exe_hold = hold_s;
    assign fwd_rj   = fwd_rj_s;
    assign fwd_rk   = fwd_rk_s;

    // Slot advance, divider hold sequencing and reset
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid_r <= 1'b0;
            exe_we_r    <= 1'b0;
            exe_ld_r    <= 1'b0;
            exe_rd_r    <= 5'd0;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_ld_r    <= 1'b0;
            mem_rd_r    <= 5'd0;
            wb_valid_r  <= 1'b0;
            wb_we_r     <= 1'b0;
            wb_ld_r     <= 1'b0;
            wb_rd_r     <= 5'd0;
            div_cnt_r   <= CNT_ZERO;
        end else if (hold_s) begin
            // EXE keeps the divide; MEM receives a bubble while WB drains
            wb_valid_r  <= mem_valid_r;
            wb_we_r     <= mem_we_r;
            wb_ld_r     <= mem_ld_r;
            wb_rd_r     <= mem_rd_r;
            mem_valid_r <= 1'b0;
            div_cnt_r   <= div_cnt_r - CNT_ONE;
        end else begin
            wb_valid_r  <= mem_valid_r;
            wb_we_r     <= mem_we_r;
            wb_ld_r     <= mem_ld_r;
            wb_rd_r     <= mem_rd_r;
            mem_valid_r <= exe_valid_r;
            mem_we_r    <= exe_we_r;
            mem_ld_r    <= exe_ld_r;
            mem_rd_r    <= exe_rd_r;
            exe_valid_r <= issue_s;
            exe_we_r    <= id_rf_we;
            exe_ld_r    <= id_is_load;
            exe_rd_r    <= id_rd;
            if (issue_s && id_is_div) begin
                div_cnt_r <= DIV_LOAD;
            end else begin
                div_cnt_r <= div_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl (DIV_LAT = 4). Inputs change on the
//   falling edge; outputs are sampled 1 time unit later and compared against
//   hand-computed vectors {stall_if, stall_id, flush_if, flush_id, issue,
//   exe_hold, fwd_rj, fwd_rk}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rj, id_rk, id_rd;
    logic       id_use_rj, id_use_rk, id_rf_we, id_is_load, id_is_div;
    logic       exe_br_taken;
    logic       stall_if, stall_id, flush_if, flush_id, issue, exe_hold;
    logic [1:0] fwd_rj, fwd_rk;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.DIV_LAT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rj        (id_rj),
        .id_rk        (id_rk),
        .id_rd        (id_rd),
        .id_use_rj    (id_use_rj),
        .id_use_rk    (id_use_rk),
        .id_rf_we     (id_rf_we),
        .id_is_load   (id_is_load),
        .id_is_div    (id_is_div),
        .exe_br_taken (exe_br_taken),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .issue        (issue),
        .exe_hold     (exe_hold),
        .fwd_rj       (fwd_rj),
        .fwd_rk       (fwd_rk)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ex(input logic st, input logic fl,
                                      input logic is, input logic hd,
                                      input logic [1:0] fj, input logic [1:0] fk);
        return {st, st, fl, fl, is, hd, fj, fk};
    endfunction

    // Wait for the falling edge and apply a new ID instruction.
    task automatic drive(input logic v, input logic [4:0] rj, input logic [4:0] rk,
                         input logic [4:0] rd, input logic urj, input logic urk,
                         input logic we, input logic ld, input logic dv,
                         input logic br);
        @(negedge clk);
        id_valid     = v;
        id_rj        = rj;
        id_rk        = rk;
        id_rd        = rd;
        id_use_rj    = urj;
        id_use_rk    = urk;
        id_rf_we     = we;
        id_is_load   = ld;
        id_is_div    = dv;
        exe_br_taken = br;
    endtask

    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        #1;
        obs = {stall_if, stall_id, flush_if, flush_id, issue, exe_hold, fwd_rj, fwd_rk};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check(tag, ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_rj = 5'd0; id_rk = 5'd0; id_rd = 5'd0;
        id_use_rj = 1'b0; id_use_rk = 1'b0; id_rf_we = 1'b0;
        id_is_load = 1'b0; id_is_div = 1'b0; exe_br_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state: nothing in ID, all outputs low
        idle("reset_idle");

        // ALU chain: add r5 issues, then consumers see it in EXE, MEM, WB
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("alu_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fwd_exe", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0));
        drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fwd_mem_exe", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1));
        drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fwd_wb_r0", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0));
        idle("drain_a1");
        idle("drain_a2");

        // Load-use: one stall cycle, then MEM forwarding
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("load_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd2, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("load_use_stall", ex(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd2, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("load_use_resolve", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2));

        // Load in EXE but consumer does not read rk: no stall
        drive(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("load2_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd3, 5'd9, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("no_use_rk", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));

        // Load writing r0, consumer reads r0: no hazard, no forwarding
        drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ld_r0_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("r0_no_hazard", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        idle("drain_b1");
        idle("drain_b2");
        idle("drain_b3");

        // Divide: 3 hold cycles, branch ignored during hold, then EXE forward
        drive(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("div_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("div_hold1", ex(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0));
        drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("div_hold2_br", ex(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0));
        drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("div_hold3", ex(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0));
        drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("div_release", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0));
        idle("drain_c1");
        idle("drain_c2");
        idle("drain_c3");

        // Branch taken together with load-use: flush wins, EXE gets a bubble
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("br_load_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("br_over_stall", ex(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd14, 5'd5, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_flush", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2));
        idle("drain_d1");
        idle("drain_d2");
        idle("drain_d3");

        // Reset during the second cycle of a divide
        drive(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rdiv_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        check("rdiv_hold", ex(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0));
        drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("post_reset_issue", ex(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
